// File: rtl/q3_demux1to16_seq.sv
// Serial-to-16-bit demux: bits land at index S; a completed word appears in A one cycle after its 16th bit.
// Backpressure: A is held until a_ready; a word completing while A is unconsumed is dropped and flags overrun.
module q3_demux1to16_seq (
   input  logic        clk,
   input  logic        rstn,
   input  logic        w,
   input  logic        w_valid,
   input  logic        clr,
   output logic [3:0]  S,
   output logic [15:0] A,
   output logic        a_valid,
   input  logic        a_ready,
   output logic        overrun
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [3:0]  sel_q;
   logic [15:0] staging_q;
   logic [15:0] a_q;
   logic        overrun_q;
   logic        complete;
   logic [15:0] candidate;
   logic        load_a;

   // Bit 15 bypasses staging so the full word is available on the completion edge itself.
   assign complete  = w_valid && !clr && (sel_q == 4'hF);
   assign candidate = {w, staging_q[14:0]};
   assign load_a    = complete && ((state_q == EMPTY) || a_ready);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         sel_q     <= 4'h0;
         staging_q <= 16'h0000;
      end else if (clr) begin
         sel_q     <= 4'h0;
         staging_q <= 16'h0000;
      end else if (w_valid) begin
         sel_q <= sel_q + 4'h1;
         if (complete) begin
            staging_q <= 16'h0000;
         end else begin
            staging_q[sel_q] <= w;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= EMPTY;
         a_q       <= 16'h0000;
         overrun_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load_a) begin
            a_q <= candidate;
         end
         if (clr) begin
            overrun_q <= 1'b0;
         end else if (complete && (state_q == FULL) && !a_ready) begin
            overrun_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: begin
            if (complete) begin
               state_d = FULL;
            end
         end
         FULL: begin
            if (!complete && a_ready) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      a_valid = (state_q == FULL);
      S       = sel_q;
      A       = a_q;
      overrun = overrun_q;
   end

endmodule

// File: tb/tb_q3_demux1to16_seq.sv
// Directed bench for q3_demux1to16_seq with a word-level reference model checked every cycle.
module tb_q3_demux1to16_seq;

   logic        clk = 1'b0;
   logic        rstn;
   logic        w;
   logic        w_valid;
   logic        clr;
   logic [3:0]  S;
   logic [15:0] A;
   logic        a_valid;
   logic        a_ready;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   // Reference model: count of bits received, integer accumulator, output holding state.
   int  m_cnt = 0;
   int  m_acc = 0;
   int  m_a   = 0;
   bit  m_full = 0;
   bit  m_ovr  = 0;
   bit  known  = 0;

   q3_demux1to16_seq dut (
      .clk     (clk),
      .rstn    (rstn),
      .w       (w),
      .w_valid (w_valid),
      .clr     (clr),
      .S       (S),
      .A       (A),
      .a_valid (a_valid),
      .a_ready (a_ready),
      .overrun (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      bit comp;
      int word;
      comp = 0;
      word = 0;
      if (!rstn) begin
         m_cnt = 0; m_acc = 0; m_a = 0; m_full = 0; m_ovr = 0; known = 1;
      end else begin
         if (clr) begin
            m_cnt = 0; m_acc = 0; m_ovr = 0;
         end else if (w_valid) begin
            m_acc = m_acc + (int'(w) << m_cnt);
            m_cnt = m_cnt + 1;
            if (m_cnt == 16) begin
               comp = 1; word = m_acc; m_cnt = 0; m_acc = 0;
            end
         end
         if (comp) begin
            if (!m_full || a_ready) m_a = word;
            else                    m_ovr = 1;
            m_full = 1;
         end else if (m_full && a_ready) begin
            m_full = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (known) begin
         chk("model_S",       {28'd0, S},       m_cnt);
         chk("model_A",       {16'd0, A},       m_a);
         chk("model_a_valid", {31'd0, a_valid}, {31'd0, m_full});
         chk("model_overrun", {31'd0, overrun}, {31'd0, m_ovr});
      end
   end

   task automatic step(input bit r, input bit v, input bit b, input bit c, input bit rdy);
      rstn = r; w_valid = v; w = b; clr = c; a_ready = rdy;
      @(negedge clk);
   endtask

   task automatic send_word(input logic [15:0] word, input bit gap, input bit rdy_last);
      logic [15:0] wd;
      wd = word;
      for (int i = 0; i < 16; i++) begin
         step(1, 1, wd[i], 0, (i == 15) ? rdy_last : 1'b0);
         if (gap && i != 15) step(1, 0, 1'b1, 0, 0);
      end
   endtask

   initial begin
      logic [15:0] wd;
      rstn = 0; w_valid = 0; w = 0; clr = 0; a_ready = 0;
      // Reset held with w_valid toggling.
      step(0, 1, 1, 0, 0);
      step(0, 0, 1, 0, 1);
      chk("rst_A", {16'd0, A}, 32'h0);
      chk("rst_a_valid", {31'd0, a_valid}, 32'h0);
      chk("rst_S", {28'd0, S}, 32'h0);
      chk("rst_overrun", {31'd0, overrun}, 32'h0);

      send_word(16'd64, 0, 0);
      chk("w64_A", {16'd0, A}, 32'h0040);
      chk("w64_a_valid", {31'd0, a_valid}, 32'h1);
      chk("w64_S", {28'd0, S}, 32'h0);

      send_word(16'd16384, 0, 0);
      chk("ovr_set", {31'd0, overrun}, 32'h1);
      chk("ovr_A_held", {16'd0, A}, 32'h0040);
      step(1, 0, 0, 1, 0);
      chk("ovr_clr", {31'd0, overrun}, 32'h0);
      chk("clr_keeps_valid", {31'd0, a_valid}, 32'h1);
      step(1, 0, 0, 0, 1);
      chk("consume_valid", {31'd0, a_valid}, 32'h0);
      chk("consume_A_kept", {16'd0, A}, 32'h0040);

      // Every-other-cycle stream; stop before the 16th bit to inspect.
      wd = 16'd65534;
      for (int i = 0; i < 15; i++) begin
         step(1, 1, wd[i], 0, 0);
         step(1, 0, 0, 0, 0);
      end
      chk("gap_S15", {28'd0, S}, 32'hF);
      chk("gap_not_yet", {31'd0, a_valid}, 32'h0);
      step(1, 1, wd[15], 0, 0);
      chk("gap_A", {16'd0, A}, 32'hFFFE);
      chk("gap_S0", {28'd0, S}, 32'h0);

      send_word(16'hA023, 0, 1);
      chk("race_A", {16'd0, A}, 32'hA023);
      chk("race_valid", {31'd0, a_valid}, 32'h1);
      chk("race_ovr", {31'd0, overrun}, 32'h0);
      step(1, 0, 0, 0, 1);

      for (int i = 0; i < 7; i++) step(1, 1, 1'b1, 0, 0);
      chk("partial_S7", {28'd0, S}, 32'h7);
      step(1, 1, 1, 1, 0);
      chk("clr_S", {28'd0, S}, 32'h0);
      send_word(16'd2, 0, 0);
      chk("after_clr_A", {16'd0, A}, 32'h0002);
      step(1, 0, 0, 0, 1);

      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) step(1, 1, 1'b1, 0, 0);
      step(0, 1, 1, 0, 0);
      chk("rst_mid_S", {28'd0, S}, 32'h0);
      chk("rst_mid_A", {16'd0, A}, 32'h0);
      send_word(16'd2, 0, 0);
      chk("after_rst_A", {16'd0, A}, 32'h0002);
      chk("after_rst_valid", {31'd0, a_valid}, 32'h1);

      step(1, 0, 0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/q3_demux1to16_seq.md
Q3_DEMUX1TO16_SEQ -- requirements
Module: q3_demux1to16_seq

Interface
REQ-001 Parameters: none; word width fixed at 16 bits, select width fixed at 4 bits.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 w  input  1  serial data bit to be routed into one word position.
REQ-005 w_valid  input  1  w is sampled on this edge when high.
REQ-006 clr  input  1  synchronous abort of the partial word and clear of overrun.
REQ-007 S  output  4  index of the word position the next valid bit is written to.
REQ-008 A  output  16  last completed word, holding register.
REQ-009 a_valid  output  1  A holds an unconsumed word.
REQ-010 a_ready  input  1  consumer accepts A on an edge where a_valid=1.
REQ-011 overrun  output  1  sticky flag, a completed word was dropped.

Function
REQ-012 Internal 16-bit staging register; on edge with w_valid=1 and clr=0: staging[S] <= w, S <= S+1.
REQ-013 Bit order: first valid bit after reset/clr/completion lands in bit 0; 16th lands in bit 15.
REQ-014 S wraps 15 -> 0 on the edge that samples the 16th bit; that edge is the completion edge.
REQ-015 Completion edge: the full word, with bit 15 taken directly from w, is the candidate; staging is cleared to 0.
REQ-016 w_valid=0: S and staging hold; no gap limit; bits need not be consecutive cycles.
REQ-017 Output FSM states: EMPTY (a_valid=0), FULL (a_valid=1).
REQ-018 EMPTY + completion -> A <= candidate, go FULL; latency: A/a_valid visible the cycle after the 16th valid bit.
REQ-019 FULL + a_ready=1, no completion -> a_valid <= 0, go EMPTY; A keeps last value.
REQ-020 FULL + a_ready=1 + completion on the same edge -> A <= candidate, stay FULL, overrun unchanged.
REQ-021 FULL + a_ready=0 + completion -> candidate discarded, A unchanged, overrun <= 1, stay FULL.
REQ-022 a_ready while EMPTY is ignored.
REQ-023 Collection continues while FULL; a new word is assembled in staging without stalling w.
REQ-024 clr=1: S <= 0, staging <= 0, overrun <= 0; any w_valid on that edge is dropped; A and a_valid unaffected.
REQ-025 clr has priority over w_valid; rstn has priority over everything.
REQ-026 overrun clears only on clr or reset.

Reset
REQ-027 rstn=0 at a rising edge: S=0, staging=0, A=16'h0000, a_valid=0, overrun=0, FSM=EMPTY.
REQ-028 Reset mid-word discards all partial bits; the next valid bit after release is bit 0.
REQ-029 Outputs driven from registers only; no combinational path from inputs to outputs.

Verification
REQ-030 rstn=0 for 2 cycles with w_valid=1 toggling -> A=0, a_valid=0, S=0, overrun=0 throughout.
REQ-031 16 consecutive valid bits of 16'd64 LSB first, a_ready=0 -> next cycle A=16'h0040, a_valid=1, S=0.
REQ-032 16'd65534 sent with w_valid high every other cycle -> A=16'hFFFE only after the 16th valid bit; S steps only on valid edges.
REQ-033 With A=16'h0040 held (a_ready=0), stream 16'd16384 to completion -> overrun=1, A stays 16'h0040; then clr -> overrun=0.
REQ-034 a_ready=1 exactly on the completion edge of 16'hA023 while FULL -> A=16'hA023, a_valid stays 1, overrun=0.
REQ-035 After 7 valid bits assert clr (with w_valid=1) -> S=0; next 16 bits of 16'd2 -> A=16'h0002; repeat with rstn=0 instead of clr -> same result.
